// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   - scan_state_t : one scan state per driven column (COL0..COL3)
//   - KEY_NONE     : internal 5-bit candidate sentinel {valid, code}
//   - key_map()    : row/column position to hex key code
package keypad_pkg;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } scan_state_t;

    // Candidate format is {valid, code}; valid=0 means no single key closed.
    localparam logic [4:0] KEY_NONE = 5'b0_0000;

    // Index is row*4 + col, matching the Pmod KYPD legend:
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        code = 4'h0;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the decoded key outputs.
//   row       : keypad rows, pulled up, low = closed in driven column
//   col       : column drive, exactly one bit low
//   key_code  : hex code of the accepted key
//   key_valid : one-clock strobe on a newly accepted key (or repeat)
//   key_held  : high while the accepted state is a key
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, output key_code, output key_valid, output key_held);
    modport slave  (output row, input col, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider producing a one-cycle tick enable
// every TICK_DIV clocks (counter 0..TICK_DIV-1, tick on the last count).
//   clock   : system clock
//   reset_n : synchronous active-low reset, clears the counter
//   o_tick  : one-cycle enable (not a derived clock)
module keypad_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clock,
    input  logic reset_n,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TICK_DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column per tick, debounces
// whole-frame results, rejects multi-key (ghost) frames and presents the
// accepted key as a hex code with a one-clock strobe and a held level.
//   clock   : system clock
//   reset_n : synchronous active-low reset
//   io_kp   : keypad_scanner_if.master (row in; col, key_code, key_valid,
//             key_held out)
// Optional auto-repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_DIV            = 100000,
    parameter int DEBOUNCE_FRAMES     = 5,
    parameter int REPEAT_DELAY_FRAMES = 125,
    parameter int REPEAT_RATE_FRAMES  = 25
) (
    input  logic                clock,
    input  logic                reset_n,
    keypad_scanner_if.master    io_kp
);
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

    genvar gi;

    if (TICK_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameter value");
    end

    logic        w_tick;
    logic [3:0]  r_row_meta, r_row_sync;
    scan_state_t r_state, w_state_next;
    logic [1:0]  w_col_idx;
    logic [15:0] r_frame, w_frame_now;
    logic [3:0]  w_idx;
    logic [4:0]  w_cand, r_prev_cand;
    logic [SW-1:0] r_stable, w_stable_next;
    logic        w_eval, w_same, w_accept, w_new_key, w_release, w_repeat;
    logic [3:0]  r_code;
    logic        r_held, r_valid;

    keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .o_tick (w_tick)
    );

    // Scan state register and next-state logic: advance one column per tick.
    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= COL0;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                COL0:    w_state_next = COL1;
                COL1:    w_state_next = COL2;
                COL2:    w_state_next = COL3;
                default: w_state_next = COL0;
            endcase
        end
    end

    assign w_col_idx = r_state;

    for (gi = 0; gi < 4; gi++) begin : g_col
        assign io_kp.col[gi] = (w_col_idx != 2'(gi));
    end

    // Frame bits (row*4 + col, 1 = closed) with the currently driven column
    // replaced by the live synchronized rows, so the COL3 tick can evaluate
    // the complete frame in the same cycle it samples the last column.
    for (gi = 0; gi < 16; gi++) begin : g_frame
        assign w_frame_now[gi] = (w_col_idx == 2'(gi % 4)) ? ~r_row_sync[gi / 4] : r_frame[gi];
    end

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_now[i]) w_idx = 4'(i);
        end
    end

    // Exactly one closure is a key; zero or several (ghosting) is NONE.
    assign w_cand = ($countones(w_frame_now) == 1) ? {1'b1, key_map(w_idx)} : KEY_NONE;
    assign w_eval = w_tick && (r_state == COL3);
    assign w_same = (w_cand == r_prev_cand);

    always_comb begin
        w_stable_next = SW'(1);
        if (w_same) begin
            w_stable_next = (r_stable == SW'(DEBOUNCE_FRAMES)) ? r_stable : r_stable + SW'(1);
        end
    end

    // Accept only when the count first reaches the threshold; a saturated
    // count that stays saturated on an identical frame is not a new event.
    assign w_accept  = w_eval && (w_stable_next == SW'(DEBOUNCE_FRAMES)) &&
                       !(w_same && (r_stable == SW'(DEBOUNCE_FRAMES)));
    assign w_new_key = w_accept && w_cand[4] && (!r_held || (r_code != w_cand[3:0]));
    assign w_release = w_accept && !w_cand[4];

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] r_rep_cnt, w_rep_target;
    logic          r_rep_rate;

    // First repeat waits the delay, later ones use the rate.
    assign w_rep_target = r_rep_rate ? RW'(REPEAT_RATE_FRAMES) : RW'(REPEAT_DELAY_FRAMES);
    assign w_repeat     = w_eval && r_held && !w_new_key && !w_release &&
                          ((r_rep_cnt + RW'(1)) == w_rep_target);

    always_ff @(posedge clock) begin
        if (!reset_n || w_new_key || w_release) begin
            r_rep_cnt  <= '0;
            r_rep_rate <= 1'b0;
        end else if (w_eval && r_held) begin
            if (w_repeat) begin
                r_rep_cnt  <= '0;
                r_rep_rate <= 1'b1;
            end else begin
                r_rep_cnt  <= r_rep_cnt + RW'(1);
            end
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_row_meta  <= '0;
            r_row_sync  <= '0;
            r_frame     <= '0;
            r_prev_cand <= KEY_NONE;
            r_stable    <= '0;
            r_code      <= '0;
            r_held      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_row_meta <= io_kp.row;
            r_row_sync <= r_row_meta;
            r_valid    <= w_new_key || w_repeat;
            if (w_tick) r_frame <= w_frame_now;
            if (w_eval) begin
                r_prev_cand <= w_cand;
                r_stable    <= w_stable_next;
            end
            if (w_new_key) begin
                r_code <= w_cand[3:0];
                r_held <= 1'b1;
            end else if (w_release) begin
                r_held <= 1'b0;
            end
        end
    end

    assign io_kp.key_code  = r_code;
    assign io_kp.key_valid = r_valid;
    assign io_kp.key_held  = r_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized keypad presses against a
// frame-level reference model (candidate history, trailing-run debounce).
module tb_keypad_scanner;
    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int RDLY     = 4;
    localparam int RRATE    = 2;
    localparam int FRAME    = 4 * TICK_DIV;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c closed

    int checks   = 0;
    int failures = 0;

    logic [4:0] hist[$];
    bit         acc_held = 1'b0;
    logic [3:0] acc_code = 4'h0;
    int         rep_f    = 0;
    logic [3:0] keymap [16];

    keypad_scanner_if kif();

    keypad_scanner #(
        .TICK_DIV           (TICK_DIV),
        .DEBOUNCE_FRAMES    (DEB),
        .REPEAT_DELAY_FRAMES(RDLY),
        .REPEAT_RATE_FRAMES (RRATE)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .io_kp  (kif)
    );

    always #5 clock = ~clock;

    // Passive matrix: a row is pulled low if any closed key in it sits on
    // the column currently driven low.
    function automatic logic [3:0] row_model(input logic [15:0] p, input logic [3:0] col);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[r*4+c] && !col[c]) rows[r] = 1'b0;
        return rows;
    endfunction

    assign kif.row = row_model(pressed, kif.col);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cand_of(input logic [15:0] p);
        if ($countones(p) != 1) return 5'b0;
        for (int i = 0; i < 16; i++) if (p[i]) return {1'b1, keymap[i]};
        return 5'b0;
    endfunction

    // One frame of the reference: accept when the trailing run of identical
    // candidates is exactly DEB long; returns whether a strobe is expected.
    function automatic bit model_frame(input logic [4:0] c);
        int run;
        bit strobe;
        bit fresh;
        strobe = 1'b0;
        fresh  = 1'b0;
        hist.push_back(c);
        while (hist.size() > 8) void'(hist.pop_front());
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != c) break;
            run++;
        end
        if (run == DEB) begin
            if (c[4]) begin
                if (!acc_held || acc_code != c[3:0]) begin
                    strobe   = 1'b1;
                    fresh    = 1'b1;
                    acc_held = 1'b1;
                    acc_code = c[3:0];
                    rep_f    = 0;
                end
            end else begin
                acc_held = 1'b0;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        if (acc_held && !fresh) begin
            rep_f++;
            if (rep_f == RDLY || (rep_f > RDLY && ((rep_f - RDLY) % RRATE) == 0)) strobe = 1'b1;
        end
`endif
        return strobe;
    endfunction

    // Runs n clocks of a frame that started right after the reset/previous
    // frame edge, checking column drive and the strobe every clock.
    task automatic run_clocks(input int n);
        logic [4:0] c;
        logic [3:0] one;
        logic [3:0] exp_col;
        bit         exp_v;
        c   = cand_of(pressed);
        one = 4'b0001;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            exp_v   = (k == FRAME) ? model_frame(c) : 1'b0;
            exp_col = ~(one << ((k / TICK_DIV) % 4));
            check("col", 8'(kif.col), 8'(exp_col));
            check("key_valid", 8'(kif.key_valid), 8'(exp_v));
        end
    endtask

    task automatic hold(input logic [15:0] p, input int frames);
        pressed = p;
        for (int f = 0; f < frames; f++) begin
            run_clocks(FRAME);
            check("key_held", 8'(kif.key_held), 8'(acc_held));
            check("key_code", 8'(kif.key_code), 8'(acc_code));
            $display("frame pressed=%04h held=%0b code=%h", p, kif.key_held, kif.key_code);
        end
    endtask

    task automatic do_reset(input int clocks);
        reset_n = 1'b0;
        repeat (clocks) @(posedge clock);
        #1;
        reset_n = 1'b1;
        hist.delete();
        acc_held = 1'b0;
        acc_code = 4'h0;
        rep_f    = 0;
        check("rst_col", 8'(kif.col), 8'h0E);
        check("rst_code", 8'(kif.key_code), 8'h00);
        check("rst_valid", 8'(kif.key_valid), 8'h00);
        check("rst_held", 8'(kif.key_held), 8'h00);
    endtask

    initial begin
        int         kind;
        int         a;
        int         b;
        logic [15:0] p;

        keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

        do_reset(2);
        hold(16'h0000, 2);                       // idle rotation, no strobe

        hold(16'h0100, 5);                       // "7"
        hold(16'h0000, 4);                       // release, code stays 7

        for (int i = 0; i < 6; i++)              // bouncing "A"
            hold((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
        hold(16'h0008, 5);
        hold(16'h0000, 4);

        hold(16'h0021, 4);                       // "1"+"5" ghost-rejected
        hold(16'h0001, 4);                       // "1" alone
        hold(16'h0000, 4);

        hold(16'h8000, 4);                       // "D", then reset mid-frame
        run_clocks(7);
        do_reset(1);
        hold(16'h8000, 4);
        hold(16'h0000, 4);

        hold(16'h2000, 12);                      // "F" long hold
        hold(16'h0000, 4);

        for (int t = 0; t < 25; t++) begin
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = (a + int'($urandom_range(1, 15))) % 16;
            p    = 16'h0000;
            if (kind == 1 || kind == 2) p[a] = 1'b1;
            if (kind == 3) begin
                p[a] = 1'b1;
                p[b] = 1'b1;
            end
            hold(p, int'($urandom_range(1, 5)));
        end
        hold(16'h0000, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad (Pmod KYPD) by driving one column low at a time and sampling the rows.
- Debounces the scan result and rejects ghosting.
- Delivers a hex key code with a one-cycle valid strobe, plus a held level. These feed the entry/mode logic whose values go to the display path.

Parameters:
- TICK_DIV, 100000, clocks per scan tick (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE_FRAMES, 5, consecutive identical full-scan frames needed to accept a change; legal minimum 1.
- REPEAT_DELAY_FRAMES, 125, frames held before the first auto-repeat (optional feature only).
- REPEAT_RATE_FRAMES, 25, frames between subsequent auto-repeats (optional feature only).

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, synchronous active-low reset, sampled on posedge clock.
- row, input, 4, keypad rows (externally pulled up); low = key closed in the driven column.
- col, output, 4, keypad column drive; exactly one bit low at all times.
- key_code, output, 4, hex value of the accepted key.
- key_valid, output, 1, one-clock strobe when a new key is accepted.
- key_held, output, 1, high while the accepted state is a key.

Behaviour:
- Reset (reset_n low at posedge clock): col=4'b1110, key_code=0, key_valid=0, key_held=0. Tick counter, column index, frame candidate, stable counter and synchronizer flops all clear. Reset mid-scan abandons the frame; no strobe is produced.
- Rows pass through a 2-flop synchronizer before any use.
- Tick: one-cycle pulse every TICK_DIV clocks, from a free-running counter 0..TICK_DIV-1.
- Scan FSM, one state per column: COL0, COL1, COL2, COL3.
  - In state COLc: col[c]=0 and all other bits are 1.
  - On a tick: sample the synchronized rows into the frame bits for column c, then advance c (COL3 -> COL0).
  - Each column is therefore driven for a full tick before it is sampled.
  - One frame = 4 ticks.
- Key map (row r, col c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D.
- Frame evaluation, on the tick that samples COL3:
  - 0 closures -> candidate NONE.
  - Exactly 1 closure -> candidate = mapped code.
  - 2 or more closures -> candidate NONE (ghost rejection).
- Debounce:
  - If the candidate equals the previous frame's candidate, stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise stable_cnt=1.
  - Acceptance occurs only on the frame where stable_cnt first reaches DEBOUNCE_FRAMES.
- Acceptance:
  - Candidate is key K and the accepted state is not K: key_code<=K, key_held<=1, key_valid=1 for the single clock following that tick.
  - Candidate NONE: key_held<=0; key_code retains the last key; no strobe.
  - Re-accepting the same K requires an intervening accepted NONE.
  - A direct stable change K1->K2 (no release) produces a new strobe with K2.
- Latency: a clean press applied before frame n's COL0 sample yields key_valid one clock after the COL3 tick of frame n+DEBOUNCE_FRAMES-1.
- Bounce: any frame mismatch restarts the count; a pulse shorter than DEBOUNCE_FRAMES frames is never accepted.
- key_valid is never high for two consecutive clocks.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - While key_held=1, a frame counter runs from acceptance.
  - key_valid re-strobes (same key_code) after REPEAT_DELAY_FRAMES frames, then every REPEAT_RATE_FRAMES frames.
  - The counter clears on release, on a key change, and on reset.
- Undefined: exactly one strobe per accepted press; no repeat counter is synthesized.

Decomposition:
- Shared package keypad_pkg holds:
  - The 16-entry row/column-to-code map as a constant function or array.
  - The scan state encoding (COL0..COL3).
  - The KEY_NONE sentinel for the internal candidate (5-bit: valid bit + code).
- Sub-module keypad_tick_gen: parameterized TICK_DIV divider producing a one-cycle tick enable, not a derived clock. It takes the same reset.

Test Plan (TICK_DIV=4, DEBOUNCE_FRAMES=3; 1 frame = 16 clocks):
- Reset, idle rows=4'hF -> col rotates 1110,1101,1011,0111 every 4 clocks; key_valid never asserts; key_code=0, key_held=0.
- Hold "7" (row2 low while col=1110) for 5 frames -> exactly one key_valid with key_code=4'h7 on the predicted clock; key_held=1; release -> key_held=0 after 3 frames, key_code stays 7.
- Press "A" toggling every frame (bounce) for 6 frames, then hold -> no strobe during bounce; a single strobe with 4'hA 3 frames after it stabilizes.
- Hold "1" and "5" together -> no strobe, key_held=0; release "5" with "1" held -> strobe with 4'h1.
- Hold "D", then assert reset_n=0 for 1 clock mid-frame -> all outputs at reset values; continued hold re-accepts "D" with a new strobe after 3 full frames.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY_FRAMES=4, REPEAT_RATE_FRAMES=2, hold "F" for 12 frames -> strobes at acceptance, +4, +6, +8, +10 frames, all key_code=4'hF.
